// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART serialiser fed by a word FIFO through a valid/ready handshake.
// Latency: a word pushed into an empty FIFO at edge E drives the start bit from E+1; frames drain back-to-back.
// Backpressure: in_ready = !fifo_full, registered-state only (a same-cycle pop does not open a slot).
// Ports: clk/rst (sync, active-high); in_data/in_valid/in_ready push side;
//        tx serial line (registered, idles high); busy = serialiser active;
//        fifo_count/fifo_empty/fifo_full report FIFO occupancy.
module uart_tx_fifo #(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_BITS-1:0]          in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          fifo_empty,
  output logic                          fifo_full
);

  localparam int CPB = CLK_FREQ / BAUD;
  localparam int BCW = (CPB > 2) ? $clog2(CPB) : 1;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;

  localparam logic [BCW-1:0] BAUD_LAST = BCW'(CPB - 1);
  localparam logic [3:0]     DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]     STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic           ODD_PAR   = (PARITY == 1);

  // ---------------- FIFO ----------------
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [CW-1:0]        count;
  logic                 push, pop;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CW'(FIFO_DEPTH));
  assign in_ready   = !fifo_full;
  assign fifo_count = count;
  assign push       = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  // Pointers are exactly AW bits wide, so increments wrap modulo FIFO_DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // ---------------- Serialiser ----------------
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t               state, state_nxt;
  logic [BCW-1:0]       baud_cnt, baud_nxt;
  logic [3:0]           bit_cnt, bit_nxt;
  logic [DATA_BITS-1:0] shreg, sh_nxt;
  logic                 par_bit, par_nxt;
  logic                 tx_r, tx_nxt;
  logic                 bit_end;

  assign bit_end = (baud_cnt == BAUD_LAST);
  assign busy    = (state != S_IDLE);
  assign tx      = tx_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      par_bit  <= 1'b0;
      tx_r     <= 1'b1;
    end else begin
      state    <= state_nxt;
      baud_cnt <= baud_nxt;
      bit_cnt  <= bit_nxt;
      shreg    <= sh_nxt;
      par_bit  <= par_nxt;
      tx_r     <= tx_nxt;
    end
  end

  // tx is registered, so each branch chooses the level of the bit that
  // begins at this edge rather than the bit currently on the line.
  always_comb begin
    state_nxt = state;
    baud_nxt  = (state == S_IDLE || bit_end) ? '0 : baud_cnt + 1'b1;
    bit_nxt   = bit_cnt;
    sh_nxt    = shreg;
    par_nxt   = par_bit;
    tx_nxt    = tx_r;
    pop       = 1'b0;

    case (state)
      S_IDLE: begin
        tx_nxt = 1'b1;
        if (!fifo_empty) begin
          pop       = 1'b1;
          sh_nxt    = mem[rd_ptr];
          par_nxt   = (^mem[rd_ptr]) ^ ODD_PAR;
          state_nxt = S_START;
          tx_nxt    = 1'b0;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_nxt = S_DATA;
          bit_nxt   = '0;
          tx_nxt    = shreg[0];
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_cnt == DATA_LAST) begin
            bit_nxt = '0;
            if (PARITY != 0) begin
              state_nxt = S_PARITY;
              tx_nxt    = par_bit;
            end else begin
              state_nxt = S_STOP;
              tx_nxt    = 1'b1;
            end
          end else begin
            bit_nxt = bit_cnt + 1'b1;
            sh_nxt  = shreg >> 1;
            tx_nxt  = shreg[1];
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_nxt = S_STOP;
          bit_nxt   = '0;
          tx_nxt    = 1'b1;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (bit_cnt == STOP_LAST) begin
            bit_nxt = '0;
            // Chain straight into the next start bit when more data waits.
            if (!fifo_empty) begin
              pop       = 1'b1;
              sh_nxt    = mem[rd_ptr];
              par_nxt   = (^mem[rd_ptr]) ^ ODD_PAR;
              state_nxt = S_START;
              tx_nxt    = 1'b0;
            end else begin
              state_nxt = S_IDLE;
              tx_nxt    = 1'b1;
            end
          end else begin
            bit_nxt = bit_cnt + 1'b1;
          end
        end
      end
      default: begin
        state_nxt = S_IDLE;
        tx_nxt    = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: self-checking bench for uart_tx_fifo across several parameter sets.
// Instances: 0 default (868 clk/bit), 1 8 clk/bit depth 4, 2 even parity, 3 odd parity, 4 7 data + 2 stop.
// A scoreboard queue holds pushed words; a line receiver decodes tx and pops them for comparison.
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] din = '0;
  logic [4:0] iv  = '0;

  wire  [4:0] tx_w, busy_w, rdy_w, emp_w, full_w;
  wire  [4:0] cnt_a, cnt_c, cnt_d, cnt_e;
  wire  [2:0] cnt_b;

  always #5 clk = ~clk;

  uart_tx_fifo u_a (
    .clk(clk), .rst(rst), .in_data(din), .in_valid(iv[0]), .in_ready(rdy_w[0]),
    .tx(tx_w[0]), .busy(busy_w[0]), .fifo_count(cnt_a), .fifo_empty(emp_w[0]), .fifo_full(full_w[0]));

  uart_tx_fifo #(.CLK_FREQ(8), .BAUD(1), .FIFO_DEPTH(4)) u_b (
    .clk(clk), .rst(rst), .in_data(din), .in_valid(iv[1]), .in_ready(rdy_w[1]),
    .tx(tx_w[1]), .busy(busy_w[1]), .fifo_count(cnt_b), .fifo_empty(emp_w[1]), .fifo_full(full_w[1]));

  uart_tx_fifo #(.CLK_FREQ(8), .BAUD(1), .PARITY(2)) u_c (
    .clk(clk), .rst(rst), .in_data(din), .in_valid(iv[2]), .in_ready(rdy_w[2]),
    .tx(tx_w[2]), .busy(busy_w[2]), .fifo_count(cnt_c), .fifo_empty(emp_w[2]), .fifo_full(full_w[2]));

  uart_tx_fifo #(.CLK_FREQ(8), .BAUD(1), .PARITY(1)) u_d (
    .clk(clk), .rst(rst), .in_data(din), .in_valid(iv[3]), .in_ready(rdy_w[3]),
    .tx(tx_w[3]), .busy(busy_w[3]), .fifo_count(cnt_d), .fifo_empty(emp_w[3]), .fifo_full(full_w[3]));

  uart_tx_fifo #(.CLK_FREQ(8), .BAUD(1), .DATA_BITS(7), .STOP_BITS(2)) u_e (
    .clk(clk), .rst(rst), .in_data(din[6:0]), .in_valid(iv[4]), .in_ready(rdy_w[4]),
    .tx(tx_w[4]), .busy(busy_w[4]), .fifo_count(cnt_e), .fifo_empty(emp_w[4]), .fifo_full(full_w[4]));

  int   sel = 0;
  logic tx_s, busy_s;
  always_comb begin
    tx_s   = tx_w[sel];
    busy_s = busy_w[sel];
  end

  int   tests = 0;
  int   fails = 0;
  int   exp_q [$];
  logic samp [0:16383];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; word is captured at the following posedge.
  task automatic push(input int inst, input int d);
    iv[inst] = 1'b1;
    din      = d[7:0];
    exp_q.push_back(d);
    @(negedge clk);
    iv[inst] = 1'b0;
  endtask

  // Called at a negedge. Waits for the start bit, records one full frame one
  // sample per cycle, decodes it and compares against the scoreboard head.
  // Returns at the negedge following the frame window.
  task automatic rx_frame(input int cpb, input int dbits, input int pmode, input int stops,
                          output int gap, output int busy_hi, output logic par_bit);
    int          nb, n, glitch, exp;
    logic        mid, ep;
    logic [31:0] word;
    nb      = 1 + dbits + ((pmode != 0) ? 1 : 0) + stops;
    n       = nb * cpb;
    gap     = 0;
    busy_hi = 0;
    par_bit = 1'b0;
    while (tx_s !== 1'b0 && gap < 2000) begin
      @(negedge clk);
      gap++;
    end
    if (gap >= 2000) begin
      check("rx_start_timeout", {31'd0, tx_s}, 32'd0);
      return;
    end
    for (int i = 0; i < n; i++) begin
      samp[i] = tx_s;
      if (busy_s === 1'b1) busy_hi++;
      @(negedge clk);
    end
    glitch = 0;
    for (int b = 0; b < nb; b++) begin
      mid = samp[b*cpb + cpb/2];
      for (int i = b*cpb; i < (b+1)*cpb; i++)
        if (samp[i] !== mid) glitch++;
    end
    check("bit_width", glitch, 0);
    check("start_bit", {31'd0, samp[cpb/2]}, 32'd0);
    word = '0;
    for (int k = 0; k < dbits; k++) word[k] = samp[(1+k)*cpb + cpb/2];
    if (exp_q.size() == 0) begin
      check("sb_empty", word, 32'hFFFF_FFFF);
      exp = 0;
    end else begin
      exp = exp_q.pop_front();
      check("data", word, exp);
    end
    if (pmode != 0) begin
      par_bit = samp[(1+dbits)*cpb + cpb/2];
      ep = (pmode == 1);
      for (int k = 0; k < dbits; k++) ep = ep ^ exp[k];
      check("parity", {31'd0, par_bit}, {31'd0, ep});
    end
    for (int s = 0; s < stops; s++)
      check("stop_bit", {31'd0, samp[(nb-stops+s)*cpb + cpb/2]}, 32'd1);
  endtask

  int   gap, bh, acc, bad;
  logic pb;
  int   nxt;

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    // Reset state
    check("rst_tx",    {31'd0, tx_w[0]},   32'd1);
    check("rst_busy",  {31'd0, busy_w[0]}, 32'd0);
    check("rst_count", {27'd0, cnt_a},     32'd0);
    check("rst_empty", {31'd0, emp_w[0]},  32'd1);
    check("rst_full",  {31'd0, full_w[0]}, 32'd0);
    check("rst_ready", {31'd0, rdy_w[0]},  32'd1);
    check("rst_count_b", {29'd0, cnt_b},   32'd0);

    // Default parameters: single 0x55 frame, 868 cycles per bit
    sel = 0;
    fork
      push(0, 8'h55);
      rx_frame(868, 8, 0, 1, gap, bh, pb);
    join
    check("dflt_start_latency", gap, 2);
    check("dflt_busy_cycles", bh, 8680);
    check("dflt_idle_busy", {31'd0, busy_s}, 32'd0);
    check("dflt_idle_tx", {31'd0, tx_s}, 32'd1);

    // Three back-to-back frames at 8 clocks per bit
    sel = 1;
    fork
      begin
        push(1, 8'h41);
        push(1, 8'h42);
        push(1, 8'h43);
        check("b2b_count", {29'd0, cnt_b}, 32'd2);
      end
      begin
        int total;
        total = 0;
        for (int f = 0; f < 3; f++) begin
          rx_frame(8, 8, 0, 1, gap, bh, pb);
          total += bh;
          if (f == 0) check("b2b_first_gap", gap, 2);
          else        check("b2b_gap", gap, 0);
          if (f == 2) check("b2b_empty", {31'd0, emp_w[1]}, 32'd1);
        end
        check("b2b_busy_total", total, 240);
        check("b2b_idle_busy", {31'd0, busy_s}, 32'd0);
      end
    join

    // Hold in_valid high with incrementing data against a depth-4 FIFO
    nxt = 8'h10;
    acc = 0;
    fork
      begin
        for (int c = 0; c < 25; c++) begin
          iv[1] = 1'b1;
          din   = nxt[7:0];
          if (rdy_w[1]) begin
            exp_q.push_back(nxt);
            nxt++;
            acc++;
          end
          @(negedge clk);
        end
        check("full_accepted", acc, 5);
        check("full_ready", {31'd0, rdy_w[1]}, 32'd0);
        check("full_count", {29'd0, cnt_b}, 32'd4);
        check("full_flag", {31'd0, full_w[1]}, 32'd1);
        iv[1] = 1'b0;
      end
      begin
        for (int f = 0; f < 5; f++) begin
          rx_frame(8, 8, 0, 1, gap, bh, pb);
          if (f == 0) check("full_first_gap", gap, 2);
          else        check("full_gap", gap, 0);
        end
      end
    join
    check("full_sb_drained", exp_q.size(), 0);
    check("full_idle_busy", {31'd0, busy_s}, 32'd0);

    // Parity: 0x07 has odd weight
    sel = 2;
    fork
      push(2, 8'h07);
      rx_frame(8, 8, 2, 1, gap, bh, pb);
    join
    check("even_parity_bit", {31'd0, pb}, 32'd1);
    check("even_busy", bh, 88);
    sel = 3;
    fork
      push(3, 8'h07);
      rx_frame(8, 8, 1, 1, gap, bh, pb);
    join
    check("odd_parity_bit", {31'd0, pb}, 32'd0);

    // 7 data bits, 2 stop bits
    sel = 4;
    fork
      push(4, 8'h7F);
      rx_frame(8, 7, 0, 2, gap, bh, pb);
    join
    check("7d2s_busy", bh, 80);
    check("7d2s_idle_busy", {31'd0, busy_s}, 32'd0);

    // Reset during data bit 3 with two words queued
    sel = 1;
    push(1, 8'hA5);
    push(1, 8'h3C);
    push(1, 8'hF0);
    exp_q.delete();
    check("rst_mid_queued", {29'd0, cnt_b}, 32'd2);
    repeat (33) @(negedge clk);
    check("rst_mid_busy_before", {31'd0, busy_s}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_tx", {31'd0, tx_s}, 32'd1);
    check("rst_mid_busy", {31'd0, busy_s}, 32'd0);
    check("rst_mid_count", {29'd0, cnt_b}, 32'd0);
    check("rst_mid_empty", {31'd0, emp_w[1]}, 32'd1);
    bad = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (tx_s !== 1'b1 || busy_s !== 1'b0) bad++;
    end
    check("rst_mid_quiet", bad, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
